// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: register address, data word and the hardwired-zero register index.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [WORD_W-1:0]     word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one register; ovf_o/unf_o pulse combinationally
// when an unmatched inc/dec hits a saturated bound (the counter then holds).
module sb_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A matched inc+dec in one cycle is a net no-op and never flags an error.
    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) begin
                ovf_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) begin
                unf_o = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with zero-latency reads, 1-cycle writes and a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads and busy release on the retiring cycle.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int  NUM_REGS = 32,
    parameter int  DATA_W   = 32,
    parameter int  CNT_W    = 3,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              sb_overflow,
    output logic              sb_underflow
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt [NUM_REGS];
    logic [NUM_REGS-1:0] ovf_vec;
    logic [NUM_REGS-1:0] unf_vec;
    logic sb_ovf_q;
    logic sb_unf_q;
    logic wb_en;

    assign wb_en = wb_regwrite && (wb_write_reg != ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_en) begin
            mem_q[wb_write_reg] <= wb_data;
        end
    end

    // r0 has no counter: it can never be busy and never flags an error.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign cnt[r]     = '0;
            assign ovf_vec[r] = 1'b0;
            assign unf_vec[r] = 1'b0;
        end else begin : g_cnt
            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc_i (issue_valid && (issue_dst == ADDR_W'(r))),
                .dec_i (wb_regwrite && (wb_write_reg == ADDR_W'(r))),
                .cnt_o (cnt[r]),
                .ovf_o (ovf_vec[r]),
                .unf_o (unf_vec[r])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_ovf_q <= 1'b0;
            sb_unf_q <= 1'b0;
        end else begin
            sb_ovf_q <= sb_ovf_q | (|ovf_vec);
            sb_unf_q <= sb_unf_q | (|unf_vec);
        end
    end

    assign sb_overflow  = sb_ovf_q;
    assign sb_underflow = sb_unf_q;

`ifdef REGFILE_BYPASS_EN
    logic rs_hit;
    logic rt_hit;

    assign rs_hit = wb_en && (wb_write_reg == rs_addr);
    assign rt_hit = wb_en && (wb_write_reg == rt_addr);

    // The last outstanding writer retiring now makes the operand available this cycle.
    always_comb begin
        rs_data = (rs_addr == ZERO_ADDR) ? '0 : (rs_hit ? wb_data : mem_q[rs_addr]);
        rt_data = (rt_addr == ZERO_ADDR) ? '0 : (rt_hit ? wb_data : mem_q[rt_addr]);
        rs_busy = (cnt[rs_addr] != '0) && !(rs_hit && (cnt[rs_addr] == CNT_ONE));
        rt_busy = (cnt[rt_addr] != '0) && !(rt_hit && (cnt[rt_addr] == CNT_ONE));
    end
`else
    always_comb begin
        rs_data = (rs_addr == ZERO_ADDR) ? '0 : mem_q[rs_addr];
        rt_data = (rt_addr == ZERO_ADDR) ? '0 : mem_q[rt_addr];
        rs_busy = (cnt[rs_addr] != '0);
        rt_busy = (cnt[rt_addr] != '0);
    end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: expected values are queued as stimulus is driven and popped when the DUT output is sampled.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        rs_busy, rt_busy;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic        wb_regwrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_data;
    logic        sb_overflow, sb_underflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    regfile_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .issue_valid  (issue_valid),
        .issue_dst    (issue_dst),
        .wb_regwrite  (wb_regwrite),
        .wb_write_reg (wb_write_reg),
        .wb_data      (wb_data),
        .sb_overflow  (sb_overflow),
        .sb_underflow (sb_underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with no expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_dst    = 5'd0;
        wb_regwrite  = 1'b0;
        wb_write_reg = 5'd0;
        wb_data      = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r);
        idle();
        issue_valid = 1'b1;
        issue_dst   = r;
        step();
        idle();
    endtask

    task automatic retire(input logic [4:0] r, input logic [31:0] d);
        idle();
        wb_regwrite  = 1'b1;
        wb_write_reg = r;
        wb_data      = d;
        step();
        idle();
    endtask

    initial begin
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        do_reset();

        // 1: reset state on every address through both ports
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            push("rst_rs_data", 32'd0);  check(rs_data);
            push("rst_rt_data", 32'd0);  check(rt_data);
            push("rst_busy", 32'd0);     check({30'd0, rs_busy, rt_busy});
        end
        push("rst_ovf", 32'd0); check({31'd0, sb_overflow});
        push("rst_unf", 32'd0); check({31'd0, sb_underflow});

        // 2: write and read back, r0 stays zero
        issue(5'd5);
        retire(5'd5, 32'hDEADBEEF);
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        #1;
        push("r5_rs_data", 32'hDEADBEEF); check(rs_data);
        push("r5_rt_data", 32'hDEADBEEF); check(rt_data);
        push("r5_busy", 32'd0);           check({31'd0, rs_busy});
        retire(5'd0, 32'h00001234);
        rs_addr = 5'd0;
        #1;
        push("r0_data", 32'd0); check(rs_data);
        push("r0_busy", 32'd0); check({31'd0, rs_busy});
        push("t2_unf", 32'd0);  check({31'd0, sb_underflow});

        // 3: two writers in flight on r7
        issue(5'd7);
        issue(5'd7);
        rt_addr = 5'd7;
        #1;
        push("r7_busy_cnt2", 32'd1); check({31'd0, rt_busy});
        retire(5'd7, 32'h00000071);
        push("r7_busy_cnt1", 32'd1); check({31'd0, rt_busy});
        retire(5'd7, 32'h00000072);
        push("r7_busy_cnt0", 32'd0); check({31'd0, rt_busy});
        push("r7_data", 32'h00000072); check(rt_data);

        // 4: simultaneous issue and retire on r9
        issue(5'd9);
        issue_valid  = 1'b1;
        issue_dst    = 5'd9;
        wb_regwrite  = 1'b1;
        wb_write_reg = 5'd9;
        wb_data      = 32'h00000099;
        step();
        idle();
        rs_addr = 5'd9;
        #1;
        push("r9_busy", 32'd1); check({31'd0, rs_busy});
        push("r9_data", 32'h00000099); check(rs_data);
        push("t4_flags", 32'd0); check({30'd0, sb_overflow, sb_underflow});

        // 5: saturation on r3, underflow on r4
        rs_addr = 5'd3;
        for (int i = 0; i < 7; i++) issue(5'd3);
        push("r3_ovf_at7", 32'd0); check({31'd0, sb_overflow});
        issue(5'd3);
        push("r3_ovf_at8", 32'd1); check({31'd0, sb_overflow});
        for (int i = 0; i < 6; i++) retire(5'd3, 32'h33);
        push("r3_busy_held7", 32'd1); check({31'd0, rs_busy});
        retire(5'd3, 32'h33);
        push("r3_busy_drained", 32'd0); check({31'd0, rs_busy});
        push("r3_unf_clear", 32'd0); check({31'd0, sb_underflow});
        retire(5'd4, 32'h44);
        push("r4_unf", 32'd1); check({31'd0, sb_underflow});
        issue(5'd3);
        do_reset();
        push("post_rst_flags", 32'd0); check({30'd0, sb_overflow, sb_underflow});
        push("post_rst_r3_busy", 32'd0); check({31'd0, rs_busy});
        rs_addr = 5'd5;
        #1;
        push("post_rst_r5", 32'd0); check(rs_data);

        // 6: same-cycle write to a busy read address
        issue(5'd2);
        rs_addr      = 5'd2;
        wb_regwrite  = 1'b1;
        wb_write_reg = 5'd2;
        wb_data      = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("byp_rs_data", 32'hA5A5A5A5); check(rs_data);
        push("byp_rs_busy", 32'd0);        check({31'd0, rs_busy});
`else
        push("nobyp_rs_data", 32'd0); check(rs_data);
        push("nobyp_rs_busy", 32'd1); check({31'd0, rs_busy});
`endif
        step();
        idle();
        #1;
        push("r2_after_data", 32'hA5A5A5A5); check(rs_data);
        push("r2_after_busy", 32'd0);        check({31'd0, rs_busy});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
